// File: rtl/fifo_pkg.sv
// Shared widths and the lane-ordering helper for the byte-to-word packer
// and the 32-bit FIFO it feeds.
package fifo_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = 16;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  count_t;

  // Lane k of 'lanes' sits at bits [8k+7:8k]; big-endian mirrors lane 0 to the top byte.
  function automatic word_t order_lanes(input word_t lanes, input bit big_endian);
    word_t w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      if (big_endian)
        w[(LANES-1-k)*BYTE_W +: BYTE_W] = lanes[k*BYTE_W +: BYTE_W];
      else
        w[k*BYTE_W +: BYTE_W] = lanes[k*BYTE_W +: BYTE_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into 32-bit words for a downstream FIFO.
// Define WORD_PACKER_FLUSH_EN to add the flush port for zero-padded partial words.
module word_packer
  import fifo_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
`ifdef WORD_PACKER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              full,
  output logic              w_en,
  output logic [WORD_W-1:0] data_in,
  output logic [CNT_W-1:0]  word_count
);

  localparam int ASM_W = (LANES - 1) * BYTE_W;

  lane_t             cnt;
  logic [ASM_W-1:0]  asm_reg;
  word_t             word_reg;
  logic              word_valid;
  count_t            count_q;

  logic              accept;
  logic              slot_free;
  logic              last_lane;
  logic              load_full;
  logic              load_flush;
  logic              ready_base;
  word_t             lanes_merged;

  assign w_en       = word_valid & ~full;
  assign data_in    = word_reg;
  assign word_count = count_q;

  assign slot_free  = ~word_valid | w_en;
  assign last_lane  = (cnt == lane_t'(LANES - 1));
  assign ready_base = ~(word_valid & ~w_en & last_lane);
  assign accept     = in_valid & in_ready;
  assign load_full  = accept & last_lane;

  // Unfilled lanes of asm_reg are always zero, which gives flush its padding for free.
  always_comb begin
    lanes_merged = {{BYTE_W{1'b0}}, asm_reg};
    for (int k = 0; k < LANES; k++) begin
      if (accept && cnt == lane_t'(k))
        lanes_merged[k*BYTE_W +: BYTE_W] = in_data;
    end
  end

`ifdef WORD_PACKER_FLUSH_EN
  logic flush_pend;
  logic has_partial;
  logic flush_req;
  logic set_pend;

  assign has_partial = accept ? ~last_lane : (cnt != '0);
  assign flush_req   = flush | flush_pend;
  assign load_flush  = flush_req & has_partial & slot_free;
  assign set_pend    = flush & has_partial & ~slot_free;
  assign in_ready    = ready_base & ~flush_pend;

  // Pending flush blocks new bytes so the padded word holds exactly what was flushed.
  always_ff @(posedge clk) begin
    if (rst)
      flush_pend <= 1'b0;
    else if (load_flush)
      flush_pend <= 1'b0;
    else if (set_pend)
      flush_pend <= 1'b1;
  end
`else
  assign load_flush = 1'b0;
  assign in_ready   = ready_base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      asm_reg    <= '0;
      word_reg   <= '0;
      word_valid <= 1'b0;
      count_q    <= '0;
    end else begin
      // A load on the same edge as a write keeps word_valid high: back-to-back words.
      if (load_full | load_flush) begin
        word_reg   <= order_lanes(lanes_merged, BIG_ENDIAN != 0);
        word_valid <= 1'b1;
        cnt        <= '0;
        asm_reg    <= '0;
      end else begin
        if (w_en)
          word_valid <= 1'b0;
        if (accept) begin
          cnt     <= cnt + 1'b1;
          asm_reg <= lanes_merged[ASM_W-1:0];
        end
      end
      if (w_en)
        count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: little- and big-endian instances share one stimulus stream.
module tb_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        full;
`ifdef WORD_PACKER_FLUSH_EN
  logic        flush;
`endif

  logic        in_ready_le, w_en_le;
  logic [31:0] data_le;
  logic [15:0] count_le;
  logic        in_ready_be, w_en_be;
  logic [31:0] data_be;
  logic [15:0] count_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_packer #(.BIG_ENDIAN(0)) dut_le (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready_le),
`ifdef WORD_PACKER_FLUSH_EN
    .flush      (flush),
`endif
    .full       (full),
    .w_en       (w_en_le),
    .data_in    (data_le),
    .word_count (count_le)
  );

  word_packer #(.BIG_ENDIAN(1)) dut_be (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready_be),
`ifdef WORD_PACKER_FLUSH_EN
    .flush      (flush),
`endif
    .full       (full),
    .w_en       (w_en_be),
    .data_in    (data_be),
    .word_count (count_be)
  );

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    in_valid = v;
    in_data  = d;
    full     = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    full     = 1'b0;
`ifdef WORD_PACKER_FLUSH_EN
    flush    = 1'b0;
`endif
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_w_en",     32'(w_en_le),     32'h0);
    checkOutput("reset_data_in",  data_le,          32'h0);
    checkOutput("reset_in_ready", 32'(in_ready_le), 32'h1);
    checkOutput("reset_count",    32'(count_le),    32'h0);

    // Basic word, both byte orders
    applyStimulus(1'b1, 8'h11, 1'b0); tick();
    applyStimulus(1'b1, 8'h22, 1'b0); tick();
    applyStimulus(1'b1, 8'h33, 1'b0); tick();
    checkOutput("partial_no_write", 32'(w_en_le), 32'h0);
    applyStimulus(1'b1, 8'h44, 1'b0); tick();
    checkOutput("word1_w_en",    32'(w_en_le), 32'h1);
    checkOutput("word1_le_data", data_le,      32'h44332211);
    checkOutput("word1_be_data", data_be,      32'h11223344);
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    checkOutput("word1_single_pulse", 32'(w_en_le),  32'h0);
    checkOutput("word1_count",        32'(count_le), 32'h1);
    checkOutput("word1_count_be",     32'(count_be), 32'h1);

    // Sustained stream: one word every four bytes
    applyStimulus(1'b1, 8'hA0, 1'b0); tick();
    applyStimulus(1'b1, 8'hA1, 1'b0); tick();
    applyStimulus(1'b1, 8'hA2, 1'b0); tick();
    applyStimulus(1'b1, 8'hA3, 1'b0); tick();
    checkOutput("stream_w1_w_en", 32'(w_en_le), 32'h1);
    checkOutput("stream_w1_data", data_le,      32'hA3A2A1A0);
    applyStimulus(1'b1, 8'hA4, 1'b0); tick();
    checkOutput("stream_gap_w_en", 32'(w_en_le), 32'h0);
    applyStimulus(1'b1, 8'hA5, 1'b0); tick();
    applyStimulus(1'b1, 8'hA6, 1'b0); tick();
    applyStimulus(1'b1, 8'hA7, 1'b0); tick();
    checkOutput("stream_w2_w_en", 32'(w_en_le), 32'h1);
    checkOutput("stream_w2_data", data_le,      32'hA7A6A5A4);
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    checkOutput("stream_count", 32'(count_le), 32'h3);

    // Backpressure: full held across eight bytes
    applyStimulus(1'b1, 8'h01, 1'b1); tick();
    applyStimulus(1'b1, 8'h02, 1'b1); tick();
    applyStimulus(1'b1, 8'h03, 1'b1); tick();
    applyStimulus(1'b1, 8'h04, 1'b1); tick();
    checkOutput("full_hold_w_en",     32'(w_en_le),     32'h0);
    checkOutput("full_hold_data",     data_le,          32'h04030201);
    checkOutput("full_hold_in_ready", 32'(in_ready_le), 32'h1);
    applyStimulus(1'b1, 8'h05, 1'b1); tick();
    applyStimulus(1'b1, 8'h06, 1'b1); tick();
    applyStimulus(1'b1, 8'h07, 1'b1); tick();
    checkOutput("full_stable_data", data_le, 32'h04030201);
    applyStimulus(1'b1, 8'h08, 1'b1);
    checkOutput("full_8th_in_ready", 32'(in_ready_le), 32'h0);
    tick();
    checkOutput("full_8th_stall_data",  data_le,          32'h04030201);
    checkOutput("full_8th_stall_count", 32'(count_le),    32'h3);
    applyStimulus(1'b1, 8'h08, 1'b0);
    checkOutput("release_w_en",     32'(w_en_le),     32'h1);
    checkOutput("release_in_ready", 32'(in_ready_le), 32'h1);
    tick();
    checkOutput("b2b_w_en",  32'(w_en_le),  32'h1);
    checkOutput("b2b_data",  data_le,       32'h08070605);
    checkOutput("b2b_count", 32'(count_le), 32'h4);
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    checkOutput("b2b_done_w_en",  32'(w_en_le),  32'h0);
    checkOutput("b2b_done_count", 32'(count_le), 32'h5);

    // Reset mid-word discards the partial bytes and the count
    applyStimulus(1'b1, 8'h01, 1'b0); tick();
    applyStimulus(1'b1, 8'h02, 1'b0); tick();
    applyStimulus(1'b1, 8'h03, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_w_en",     32'(w_en_le),     32'h0);
    checkOutput("midrst_in_ready", 32'(in_ready_le), 32'h1);
    checkOutput("midrst_count",    32'(count_le),    32'h0);
    tick();
    checkOutput("midrst_no_write", 32'(w_en_le), 32'h0);
    applyStimulus(1'b1, 8'h55, 1'b0); tick();
    applyStimulus(1'b0, 8'hFF, 1'b0); tick();
    applyStimulus(1'b1, 8'h55, 1'b0); tick();
    applyStimulus(1'b1, 8'h55, 1'b0); tick();
    checkOutput("idle_byte_ignored", 32'(w_en_le), 32'h0);
    applyStimulus(1'b1, 8'h55, 1'b0); tick();
    checkOutput("postrst_w_en", 32'(w_en_le), 32'h1);
    checkOutput("postrst_data", data_le,      32'h55555555);
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    checkOutput("postrst_count", 32'(count_le), 32'h1);

`ifdef WORD_PACKER_FLUSH_EN
    // Flush of a partial word, then an empty flush, then flush with a same-edge byte
    applyStimulus(1'b1, 8'hAA, 1'b0); tick();
    applyStimulus(1'b1, 8'hBB, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_w_en",    32'(w_en_le), 32'h1);
    checkOutput("flush_le_data", data_le,      32'h0000BBAA);
    checkOutput("flush_be_data", data_be,      32'hAABB0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_empty_w_en", 32'(w_en_le),  32'h0);
    checkOutput("flush_count",      32'(count_le), 32'h2);
    tick();
    checkOutput("flush_empty_still_idle", 32'(w_en_le), 32'h0);
    applyStimulus(1'b1, 8'hCC, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_same_edge_le", data_le, 32'h000000CC);
    checkOutput("flush_same_edge_be", data_be, 32'hCC000000);
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    checkOutput("flush_final_count", 32'(count_le), 32'h3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 0, byte-lane order select (0: first byte to bits [7:0]; 1: first byte to bits [31:24]).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_data  input  8  upstream byte.
REQ-006 SHALL have port in_ready  output  1  byte accepted on clk edge when in_valid & in_ready.
REQ-007 SHALL have port flush  input  1  single-cycle request to emit partial word (only with macro, else ignored/absent).
REQ-008 SHALL have port full  input  1  downstream 32-bit FIFO full flag.
REQ-009 SHALL have port w_en  output  1  FIFO write strobe.
REQ-010 SHALL have port data_in  output  32  FIFO write data (named for the FIFO port it drives).
REQ-011 SHALL have port word_count  output  16  count of words written to FIFO.

Function
REQ-012 SHALL hold a 2-bit lane counter cnt (0..3), a 24-bit assembly register, a 32-bit word register and a word_valid flag.
REQ-013 SHALL store each accepted byte in lane cnt per BIG_ENDIAN and increment cnt; on the 4th byte (cnt==3) load word register with assembled word, set word_valid, cnt wraps to 0.
REQ-014 SHALL drive w_en = word_valid & !full (combinational) and data_in = word register; a write completes on an edge with w_en high.
REQ-015 SHALL clear word_valid on write completion unless a new word is loaded the same edge, in which case word_valid stays 1 with the new word (back-to-back, no bubble).
REQ-016 SHALL drive in_ready = !(word_valid & !w_en & cnt==3); bytes for lanes 0..2 are accepted while a word waits.
REQ-017 SHALL keep word register and data_in stable while word_valid & full.
REQ-018 SHALL increment word_count by 1 per completed write, wrapping 0xFFFF -> 0x0000.
REQ-019 SHALL sustain one byte per cycle and one word per 4 cycles when full is low; latency from 4th byte accept edge to w_en high is 0 cycles after that edge (w_en asserted in following cycle).
REQ-020 SHALL ignore in_data when in_valid low; cnt unchanged.

Reset
REQ-021 SHALL on rst high at an edge clear cnt, assembly register, word register, word_valid, word_count and flush-pending; w_en=0, data_in=0, in_ready=1 after that edge.
REQ-022 SHALL discard partial and pending words on reset mid-operation; no write issued in the reset cycle's following cycle.

Configuration
REQ-023 SHALL compile flush support only when macro WORD_PACKER_FLUSH_EN is defined.
REQ-024 With WORD_PACKER_FLUSH_EN: flush with cnt>0 emits assembled bytes zero-padded in unfilled lanes as a word, cnt<=0; a byte accepted the same edge is included before padding; flush with cnt==0 and no same-edge byte is ignored.
REQ-025 With WORD_PACKER_FLUSH_EN: flush while word register occupied and not draining sets sticky flush-pending, in_ready=0 until the padded word is loaded.
REQ-026 Without WORD_PACKER_FLUSH_EN: flush port absent, no flush-pending state; only full words emitted.

Structure
REQ-027 SHALL place WORD_W=32, BYTE_W=8, LANES=4, CNT_W=16 constants in shared package fifo_pkg.
REQ-028 SHALL be a single module; no sub-module required.

Verification
REQ-029 Bytes 0x11,0x22,0x33,0x44 consecutive, full=0, BIG_ENDIAN=0 -> one w_en pulse, data_in=0x44332211, word_count=1.
REQ-030 Same bytes, BIG_ENDIAN=1 -> data_in=0x11223344.
REQ-031 full=1 held, 8 bytes 0x01..0x08 offered -> first word 0x04030201 held stable, in_ready=0 at 8th byte; release full -> two writes in consecutive cycles, second 0x08070605.
REQ-032 Flush after 0xAA,0xBB (macro on) -> data_in=0x0000BBAA, cnt=0; flush with cnt=0 -> no write.
REQ-033 rst pulsed after 3 bytes, then 0x55 x4 -> only one write 0x55555555, word_count=1.
REQ-034 Stream 65536 words -> word_count wraps to 0x0000.
